pred_update_queue: RTL and testbench

//  Buffers branch-resolution info from the two commit slots and feeds the predictor's

---
 rtl/pred_update_queue.sv | 126 ++++++++++++
 tb/tb_pred_update_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_update_queue.sv
// Branch-resolution update queue: absorbs up to two retiring branches per cycle
// from commit and issues one predictor update per cycle in strict FIFO order.
module pred_update_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      in_valid,
  input  logic [31:0]     in_pc_0,
  input  logic [31:0]     in_pc_1,
  input  logic [2:0]      in_ins_type_0,
  input  logic [2:0]      in_ins_type_1,
  input  logic            in_is_cond_0,
  input  logic            in_is_cond_1,
  input  logic            in_taken_0,
  input  logic            in_taken_1,
  input  logic            in_mispred_0,
  input  logic            in_mispred_1,
  input  logic [31:0]     in_target_0,
  input  logic [31:0]     in_target_1,
  output logic            in_ready,
  output logic            branch_mistaken,
  output logic [31:0]     wrong_pc,
  output logic [31:0]     right_target,
  output logic [2:0]      ins_type_w,
  output logic            update_orien_en,
  output logic [31:0]     retire_pc,
  output logic            right_orien,
  output logic [CNTW-1:0] stat_cond_cnt,
  output logic [CNTW-1:0] stat_mispred_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ins_type;
    logic        is_cond;
    logic        taken;
    logic        mispred;
    logic [31:0] target;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  entry_t          ent_0;
  entry_t          ent_1;
  entry_t          head;
  logic            push_0;
  logic            push_1;
  logic [1:0]      n_push;
  logic            pop;

  assign ent_0 = '{pc: in_pc_0, ins_type: in_ins_type_0, is_cond: in_is_cond_0,
                   taken: in_taken_0, mispred: in_mispred_0, target: in_target_0};
  assign ent_1 = '{pc: in_pc_1, ins_type: in_ins_type_1, is_cond: in_is_cond_1,
                   taken: in_taken_1, mispred: in_mispred_1, target: in_target_1};

  // Only slots that need a predictor update are enqueued.
  assign in_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign push_0   = in_ready & in_valid[0] & (in_is_cond_0 | in_mispred_0);
  assign push_1   = in_ready & in_valid[1] & (in_is_cond_1 | in_mispred_1);
  assign n_push   = 2'(push_0) + 2'(push_1);
  assign pop      = (count != '0);
  assign head     = mem[rd_ptr];

  // Storage array: slot 0 takes wr_ptr, slot 1 follows it when both push.
  always_ff @(posedge clk) begin
    if (push_0) mem[wr_ptr] <= ent_0;
    if (push_1) mem[push_0 ? wr_ptr + AW'(1) : wr_ptr] <= ent_1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

  // Output stage: enables pulse only on a pop, data fields hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_mistaken  <= 1'b0;
      wrong_pc         <= '0;
      right_target     <= '0;
      ins_type_w       <= '0;
      update_orien_en  <= 1'b0;
      retire_pc        <= '0;
      right_orien      <= 1'b0;
      stat_cond_cnt    <= '0;
      stat_mispred_cnt <= '0;
    end else begin
      branch_mistaken <= 1'b0;
      update_orien_en <= 1'b0;
      if (pop) begin
        branch_mistaken <= head.mispred;
        wrong_pc        <= head.pc;
        right_target    <= head.target;
        ins_type_w      <= head.ins_type;
        update_orien_en <= head.is_cond;
        retire_pc       <= head.pc;
        right_orien     <= head.taken;
        if (head.is_cond && (stat_cond_cnt != '1))
          stat_cond_cnt <= stat_cond_cnt + CNTW'(1);
        if (head.mispred && (stat_mispred_cnt != '1))
          stat_mispred_cnt <= stat_mispred_cnt + CNTW'(1);
      end
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    (SW'(count) + SW'(n_push)) <= (SW'(DEPTH) + SW'(pop)));
  underflow_a: assert property (@(posedge clk) disable iff (reset)
    pop |-> (count != '0));

endmodule

// File: tb/tb_pred_update_queue.sv
// Randomized bench for pred_update_queue against a queue-based model, plus
// directed scenarios with literal expectations.
module tb_pred_update_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNTW  = 4;
  localparam logic [2:0]  BR_CALL = 3'd2;
  localparam int unsigned SAT = (1 << CNTW) - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ins_type;
    logic        is_cond;
    logic        taken;
    logic        mispred;
    logic [31:0] target;
  } ent_t;

  logic            clk;
  logic            reset;
  logic [1:0]      in_valid;
  ent_t            s0, s1;
  logic            in_ready;
  logic            branch_mistaken;
  logic [31:0]     wrong_pc;
  logic [31:0]     right_target;
  logic [2:0]      ins_type_w;
  logic            update_orien_en;
  logic [31:0]     retire_pc;
  logic            right_orien;
  logic [CNTW-1:0] stat_cond_cnt;
  logic [CNTW-1:0] stat_mispred_cnt;

  int checks = 0;
  int errors = 0;

  pred_update_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_pc_0(s0.pc), .in_pc_1(s1.pc),
    .in_ins_type_0(s0.ins_type), .in_ins_type_1(s1.ins_type),
    .in_is_cond_0(s0.is_cond), .in_is_cond_1(s1.is_cond),
    .in_taken_0(s0.taken), .in_taken_1(s1.taken),
    .in_mispred_0(s0.mispred), .in_mispred_1(s1.mispred),
    .in_target_0(s0.target), .in_target_1(s1.target),
    .in_ready(in_ready), .branch_mistaken(branch_mistaken),
    .wrong_pc(wrong_pc), .right_target(right_target), .ins_type_w(ins_type_w),
    .update_orien_en(update_orien_en), .retire_pc(retire_pc), .right_orien(right_orien),
    .stat_cond_cnt(stat_cond_cnt), .stat_mispred_cnt(stat_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending updates and the last issued one.
  ent_t q[$];
  ent_t last;
  logic exp_bm, exp_oe;
  int   exp_cc, exp_mc;

  initial begin
    last = '0; exp_bm = 1'b0; exp_oe = 1'b0; exp_cc = 0; exp_mc = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      last = '0; exp_bm = 1'b0; exp_oe = 1'b0; exp_cc = 0; exp_mc = 0;
    end else begin
      bit acc;
      acc = (DEPTH - q.size()) >= 2;
      exp_bm = 1'b0;
      exp_oe = 1'b0;
      if (q.size() != 0) begin
        last = q.pop_front();
        exp_bm = last.mispred;
        exp_oe = last.is_cond;
        if (last.is_cond && exp_cc < SAT) exp_cc++;
        if (last.mispred && exp_mc < SAT) exp_mc++;
      end
      if (acc) begin
        if (in_valid[0] && (s0.is_cond || s0.mispred)) q.push_back(s0);
        if (in_valid[1] && (s1.is_cond || s1.mispred)) q.push_back(s1);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'((DEPTH - q.size()) >= 2));
    chk("branch_mistaken", 32'(branch_mistaken), 32'(exp_bm));
    chk("update_orien_en", 32'(update_orien_en), 32'(exp_oe));
    chk("wrong_pc", wrong_pc, last.pc);
    chk("right_target", right_target, last.target);
    chk("ins_type_w", 32'(ins_type_w), 32'(last.ins_type));
    chk("retire_pc", retire_pc, last.pc);
    chk("right_orien", 32'(right_orien), 32'(last.taken));
    chk("stat_cond_cnt", 32'(stat_cond_cnt), 32'(exp_cc));
    chk("stat_mispred_cnt", 32'(stat_mispred_cnt), 32'(exp_mc));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [2:0] it, input logic c,
                              input logic t, input logic m, input logic [31:0] tg);
    ent_t e;
    e.pc = pc; e.ins_type = it; e.is_cond = c; e.taken = t; e.mispred = m; e.target = tg;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc = $urandom; e.ins_type = 3'($urandom_range(0, 4));
    e.is_cond = ($urandom_range(0, 99) < 50); e.taken = 1'($urandom);
    e.mispred = ($urandom_range(0, 99) < 30); e.target = $urandom;
    return e;
  endfunction

  task automatic idle();
    in_valid = 2'b00; s0 = '0; s1 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle();
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst stat_cond", 32'(stat_cond_cnt), 32'd0);

    // Single conditional entry: pulse two edges after it is sampled
    in_valid = 2'b01; s0 = mk(32'h1c000010, 3'd1, 1'b1, 1'b1, 1'b0, 32'h1c000020);
    step(); idle();
    chk("t1 early orien", 32'(update_orien_en), 32'd0);
    step();
    chk("t1 orien_en", 32'(update_orien_en), 32'd1);
    chk("t1 retire_pc", retire_pc, 32'h1c000010);
    chk("t1 right_orien", 32'(right_orien), 32'd1);
    chk("t1 mistaken", 32'(branch_mistaken), 32'd0);
    step();
    chk("t1 pulse end", 32'(update_orien_en), 32'd0);

    // Two slots in one cycle leave in order
    in_valid = 2'b11;
    s0 = mk(32'h100, BR_CALL, 1'b0, 1'b1, 1'b1, 32'h200);
    s1 = mk(32'h104, 3'd1, 1'b1, 1'b0, 1'b0, 32'h108);
    step(); idle();
    step();
    chk("t2 mistaken", 32'(branch_mistaken), 32'd1);
    chk("t2 wrong_pc", wrong_pc, 32'h100);
    chk("t2 right_target", right_target, 32'h200);
    chk("t2 ins_type", 32'(ins_type_w), 32'(BR_CALL));
    step();
    chk("t2b orien_en", 32'(update_orien_en), 32'd1);
    chk("t2b retire_pc", retire_pc, 32'h104);
    chk("t2b right_orien", 32'(right_orien), 32'd0);
    chk("t2b mistaken", 32'(branch_mistaken), 32'd0);

    // Non-updating branch is dropped
    in_valid = 2'b01; s0 = mk(32'h300, 3'd0, 1'b0, 1'b1, 1'b0, 32'h304);
    step(); idle(); step();
    chk("t3 no orien", 32'(update_orien_en), 32'd0);
    chk("t3 no mispred", 32'(branch_mistaken), 32'd0);

    // Sustained 2-wide pushes hit backpressure at count 7
    for (int i = 0; i < 8; i++) begin
      in_valid = 2'b11;
      s0 = mk(32'h1000 + 32'(i * 8), 3'd1, 1'b1, 1'($urandom), 1'b0, 32'h0);
      s1 = mk(32'h1004 + 32'(i * 8), 3'd1, 1'b1, 1'($urandom), 1'b0, 32'h0);
      step();
      if (i == 5) chk("t4 ready low", 32'(in_ready), 32'd0);
      if (i == 6) chk("t4 ready back", 32'(in_ready), 32'd1);
    end
    idle();
    repeat (12) step();
    chk("t4 drained ready", 32'(in_ready), 32'd1);
    chk("t4 drained en", 32'(update_orien_en), 32'd0);

    // Both enables together, stats saturate
    do_reset();
    in_valid = 2'b01; s0 = mk(32'h400, 3'd4, 1'b1, 1'b1, 1'b1, 32'h800);
    step(); idle(); step();
    chk("t5 both bm", 32'(branch_mistaken), 32'd1);
    chk("t5 both oe", 32'(update_orien_en), 32'd1);
    chk("t5 cc1", 32'(stat_cond_cnt), 32'd1);
    chk("t5 mc1", 32'(stat_mispred_cnt), 32'd1);
    for (int i = 0; i < 19; i++) begin
      in_valid = 2'b01; s0 = mk(32'h500 + 32'(i * 4), 3'd4, 1'b1, 1'b0, 1'b1, 32'h900);
      step();
    end
    idle();
    repeat (4) step();
    chk("t5 cc sat", 32'(stat_cond_cnt), 32'd15);
    chk("t5 mc sat", 32'(stat_mispred_cnt), 32'd15);

    // Reset discards queued entries
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b11; s0 = rnd_ent(); s1 = rnd_ent();
      s0.is_cond = 1'b1; s1.is_cond = 1'b1;
      step();
    end
    do_reset();
    chk("t6 ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6 no oe", 32'(update_orien_en), 32'd0);
      chk("t6 no bm", 32'(branch_mistaken), 32'd0);
    end

    // Randomized traffic with idle bursts and occasional reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        idle();
      end else begin
        reset = 1'b0;
        in_valid = ((i / 64) % 3 == 2) ? 2'b00 : 2'($urandom);
        s0 = rnd_ent(); s1 = rnd_ent();
      end
      step();
    end
    reset = 1'b0; idle();
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
